// File: rtl/decode_regfile_wb_arbiter.sv
// Write-port arbiter for the decode-stage regfile: grants one of two writeback
// requesters per cycle, stages the winner for one cycle and bypasses it to both read ports.
module decode_regfile_wb_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic [ADDR_W-1:0] waddr,
  output logic              wen,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic              fwd0_hit,
  output logic [DATA_W-1:0] fwd0_data,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data
);

  localparam bit FIXED = (FIXED_PRIO != 0);

  logic              rr_ptr;
  logic              active;
  logic              gnt0_p0;
  logic              gnt1_p0;
  logic              xfer_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;

  // Stage p0: grant selection and winner mux
  always_comb begin
    active  = !reset && !hold;
    gnt0_p0 = active && s0_valid && (!s1_valid || FIXED || !rr_ptr);
    gnt1_p0 = active && s1_valid && !gnt0_p0;
    xfer_p0 = gnt0_p0 || gnt1_p0;
    addr_p0 = gnt1_p0 ? s1_addr : s0_addr;
    data_p0 = gnt1_p0 ? s1_data : s0_data;
  end

  assign s0_ready = gnt0_p0;
  assign s1_ready = gnt1_p0;

  // Stage p1: staged regfile write; r0 targets are accepted but never enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= 1'b0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else if (xfer_p0) begin
      rr_ptr   <= gnt0_p0;
      vld_p1   <= (addr_p0 != '0);
      waddr_p1 <= addr_p0;
      wdata_p1 <= data_p0;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign wen   = vld_p1;
  assign waddr = waddr_p1;
  assign wdata = wdata_p1;

  // The regfile commits a cycle late, so reads of the staged register take the bypass
  always_comb begin
    fwd0_hit  = !reset && vld_p1 && (waddr_p1 == raddr0) && (raddr0 != '0);
    fwd1_hit  = !reset && vld_p1 && (waddr_p1 == raddr1) && (raddr1 != '0);
    fwd0_data = wdata_p1;
    fwd1_data = wdata_p1;
  end

endmodule

// File: tb/tb_decode_regfile_wb_arbiter.sv
// Directed bench for decode_regfile_wb_arbiter: round-robin and fixed-priority
// instances side by side, plus a small regfile model fed from the write port.
module tb_decode_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic        s0_valid = 1'b1, s1_valid = 1'b1;
  logic [4:0]  s0_addr = 5'd3, s1_addr = 5'd4;
  logic [31:0] s0_data = 32'h0, s1_data = 32'h0;
  logic [4:0]  raddr0 = 5'd0, raddr1 = 5'd0;

  logic        s0_ready, s1_ready, wen, fwd0_hit, fwd1_hit;
  logic [4:0]  waddr;
  logic [31:0] wdata, fwd0_data, fwd1_data;

  logic        fp_s0_ready, fp_s1_ready, fp_wen, fp_fwd0_hit, fp_fwd1_hit;
  logic [4:0]  fp_waddr;
  logic [31:0] fp_wdata, fp_fwd0_data, fp_fwd1_data;

  logic [31:0] rf [32];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .waddr(waddr), .wen(wen), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1),
    .fwd0_hit(fwd0_hit), .fwd0_data(fwd0_data), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data)
  );

  decode_regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset), .hold(hold),
    .s0_valid(s0_valid), .s0_ready(fp_s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(fp_s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .waddr(fp_waddr), .wen(fp_wen), .wdata(fp_wdata),
    .raddr0(raddr0), .raddr1(raddr1),
    .fwd0_hit(fp_fwd0_hit), .fwd0_data(fp_fwd0_data), .fwd1_hit(fp_fwd1_hit), .fwd1_data(fp_fwd1_data)
  );

  // Regfile model: commits at the edge ending the wen cycle; frozen while in reset
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(posedge clk) if (!reset && wen && waddr != 5'd0) rf[waddr] <= wdata;

  // Requester rule: a pending (valid, not ready) request keeps its payload
  logic       p0_pend = 1'b0, p1_pend = 1'b0;
  logic [4:0] p0_addr, p1_addr;
  logic [31:0] p0_data, p1_data;
  always @(posedge clk) begin
    if (!reset && p0_pend && s0_valid)
      assert (s0_addr == p0_addr && s0_data == p0_data) else $error("requester 0 payload changed while pending");
    if (!reset && p1_pend && s1_valid)
      assert (s1_addr == p1_addr && s1_data == p1_data) else $error("requester 1 payload changed while pending");
    p0_pend <= s0_valid && !s0_ready;
    p1_pend <= s1_valid && !s1_ready;
    p0_addr <= s0_addr; p0_data <= s0_data;
    p1_addr <= s1_addr; p1_data <= s1_data;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      n_cmp++; if ({s0_ready, s1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready c%0d: got %b want 00", i, {s0_ready, s1_ready}); end
      n_cmp++; if (wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen c%0d: got %b want 0", i, wen); end
      n_cmp++; if (waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr c%0d: got %0d want 0", i, waddr); end
      n_cmp++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata c%0d: got %h want 0", i, wdata); end
    end
    cyc();
    reset = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_single();
    cyc();
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF; #1;
    n_cmp++; if ({s0_ready, s1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {s0_ready, s1_ready}); end
    cyc();
    s0_valid = 1'b0; #1;
    n_cmp++; if (wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_write: got wen=%b addr=%0d data=%h want 1/5/deadbeef", wen, waddr, wdata); end
    cyc(); #1;
    n_cmp++; if (wen !== 1'b0 || waddr !== 5'd5) begin n_fail++; $display("FAIL single_idle: got wen=%b addr=%0d want 0/5", wen, waddr); end
    n_cmp++; if (rf[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf5: got %h want deadbeef", rf[5]); end
  endtask

  task automatic test_contention();
    logic exp0;
    logic [4:0] exp_addr;
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'h11;
    s1_valid = 1'b1; s1_addr = 5'd2; s1_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp0 = (k % 2 == 0);
      exp_addr = (k % 2 == 1) ? 5'd1 : 5'd2;
      n_cmp++; if ({s0_ready, s1_ready} !== {exp0, !exp0}) begin n_fail++; $display("FAIL rr_grant k%0d: got %b want %b", k, {s0_ready, s1_ready}, {exp0, !exp0}); end
      n_cmp++; if ({fp_s0_ready, fp_s1_ready} !== 2'b10) begin n_fail++; $display("FAIL fp_grant k%0d: got %b want 10", k, {fp_s0_ready, fp_s1_ready}); end
      if (k > 0) begin
        n_cmp++; if (wen !== 1'b1 || waddr !== exp_addr) begin n_fail++; $display("FAIL rr_waddr k%0d: got wen=%b addr=%0d want 1/%0d", k, wen, waddr, exp_addr); end
        n_cmp++; if (fp_wen !== 1'b1 || fp_waddr !== 5'd1) begin n_fail++; $display("FAIL fp_waddr k%0d: got wen=%b addr=%0d want 1/1", k, fp_wen, fp_waddr); end
      end
      cyc();
    end
    s0_valid = 1'b0; s1_valid = 1'b0; #1;
    n_cmp++; if (wen !== 1'b1 || waddr !== 5'd2 || wdata !== 32'h22) begin n_fail++; $display("FAIL rr_last: got wen=%b addr=%0d data=%h want 1/2/22", wen, waddr, wdata); end
  endtask

  task automatic test_r0_drop();
    cyc();
    s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1234; raddr0 = 5'd0; raddr1 = 5'd0; #1;
    n_cmp++; if ({s0_ready, s1_ready} !== 2'b01) begin n_fail++; $display("FAIL r0_ready: got %b want 01", {s0_ready, s1_ready}); end
    cyc();
    s1_valid = 1'b0; #1;
    n_cmp++; if (wen !== 1'b0) begin n_fail++; $display("FAIL r0_wen: got %b want 0", wen); end
    n_cmp++; if ({fwd0_hit, fwd1_hit} !== 2'b00) begin n_fail++; $display("FAIL r0_fwd: got %b want 00", {fwd0_hit, fwd1_hit}); end
  endtask

  task automatic test_forward();
    cyc();
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'hA5A5A5A5; #1;
    n_cmp++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ready: got %b want 1", s0_ready); end
    cyc();
    s0_valid = 1'b0; raddr0 = 5'd7; raddr1 = 5'd3; #1;
    n_cmp++; if (fwd0_hit !== 1'b1 || fwd0_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL fwd0: got hit=%b data=%h want 1/a5a5a5a5", fwd0_hit, fwd0_data); end
    n_cmp++; if (fwd1_hit !== 1'b0) begin n_fail++; $display("FAIL fwd1_miss: got %b want 0", fwd1_hit); end
    raddr1 = 5'd7; #1;
    n_cmp++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL fwd1_hit: got hit=%b data=%h want 1/a5a5a5a5", fwd1_hit, fwd1_data); end
    raddr0 = 5'd0; raddr1 = 5'd0;
  endtask

  task automatic test_hold();
    cyc();
    s0_valid = 1'b1; s0_addr = 5'd9; s0_data = 32'h99; #1;
    n_cmp++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL hold_pre_ready: got %b want 1", s0_ready); end
    cyc();
    hold = 1'b1; s1_valid = 1'b1; s1_addr = 5'd10; s1_data = 32'h10A; #1;
    n_cmp++; if ({s0_ready, s1_ready} !== 2'b00) begin n_fail++; $display("FAIL hold_ready1: got %b want 00", {s0_ready, s1_ready}); end
    n_cmp++; if (wen !== 1'b1 || waddr !== 5'd9) begin n_fail++; $display("FAIL hold_staged: got wen=%b addr=%0d want 1/9", wen, waddr); end
    cyc(); #1;
    n_cmp++; if ({s0_ready, s1_ready} !== 2'b00) begin n_fail++; $display("FAIL hold_ready2: got %b want 00", {s0_ready, s1_ready}); end
    n_cmp++; if (wen !== 1'b0) begin n_fail++; $display("FAIL hold_wen: got %b want 0", wen); end
    cyc();
    hold = 1'b0; #1;
    n_cmp++; if ({s0_ready, s1_ready} !== 2'b01) begin n_fail++; $display("FAIL hold_release: got %b want 01", {s0_ready, s1_ready}); end
    cyc();
    s0_valid = 1'b0; s1_valid = 1'b0; #1;
    n_cmp++; if (wen !== 1'b1 || waddr !== 5'd10 || wdata !== 32'h10A) begin n_fail++; $display("FAIL hold_after: got wen=%b addr=%0d data=%h want 1/10/10a", wen, waddr, wdata); end
  endtask

  task automatic test_reset_midstream();
    cyc();
    s0_valid = 1'b1; s0_addr = 5'd12; s0_data = 32'hCAFE; raddr0 = 5'd12; #1;
    n_cmp++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", s0_ready); end
    cyc();
    s0_valid = 1'b0; reset = 1'b1; #1;
    n_cmp++; if (fwd0_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fwd: got %b want 0", fwd0_hit); end
    cyc();
    reset = 1'b0; raddr0 = 5'd0; #1;
    n_cmp++; if (wen !== 1'b0 || waddr !== 5'd0) begin n_fail++; $display("FAIL rst_mid_wen: got wen=%b addr=%0d want 0/0", wen, waddr); end
    n_cmp++; if (rf[12] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rf12: got %h want 0", rf[12]); end
  endtask

  task automatic test_back_to_back();
    cyc();
    s0_valid = 1'b1; s0_addr = 5'd4; s0_data = 32'h40;
    s1_valid = 1'b1; s1_addr = 5'd4; s1_data = 32'h41; #1;
    n_cmp++; if ({s0_ready, s1_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_grant0: got %b want 10", {s0_ready, s1_ready}); end
    cyc();
    s0_valid = 1'b0; #1;
    n_cmp++; if ({s0_ready, s1_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_grant1: got %b want 01", {s0_ready, s1_ready}); end
    n_cmp++; if (wen !== 1'b1 || waddr !== 5'd4 || wdata !== 32'h40) begin n_fail++; $display("FAIL b2b_first: got wen=%b addr=%0d data=%h want 1/4/40", wen, waddr, wdata); end
    cyc();
    s1_valid = 1'b0; #1;
    n_cmp++; if (wen !== 1'b1 || wdata !== 32'h41) begin n_fail++; $display("FAIL b2b_second: got wen=%b data=%h want 1/41", wen, wdata); end
    cyc(); #1;
    n_cmp++; if (wen !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", wen); end
    n_cmp++; if (rf[4] !== 32'h41) begin n_fail++; $display("FAIL b2b_rf4: got %h want 41", rf[4]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_r0_drop();
    test_forward();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
